// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared types and violation indices for the AXI4-Lite monitor
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int VIO_AR_STABLE    = 0;
    localparam int VIO_R_STABLE     = 1;
    localparam int VIO_AW_STABLE    = 2;
    localparam int VIO_W_STABLE     = 3;
    localparam int VIO_B_STABLE     = 4;
    localparam int VIO_R_UNEXPECTED = 5;
    localparam int VIO_B_UNEXPECTED = 6;
    localparam int VIO_OVERFLOW     = 7;
    localparam int VIO_TIMEOUT      = 8;
    localparam int VIO_COUNT        = 9;

    localparam int PROT_W = 3;

    function automatic logic is_err_resp(input logic [1:0] resp);
        return (resp_t'(resp) == SLVERR) || (resp_t'(resp) == DECERR);
    endfunction

endpackage

// File: rtl/axi4_lite_chan_check.sv
// rtl/axi4_lite_chan_check.sv - per-channel valid/payload stability and stall timeout check
module axi4_lite_chan_check #(
    parameter int PW      = 8,
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic          ready,
    input  logic [PW-1:0] payload,
    output logic          stable_err,
    output logic          timeout_err
);

    localparam int SW = $clog2(TIMEOUT + 1);

    logic          stalled;
    logic          stalled_q;
    logic [PW-1:0] payload_q;
    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] stall_next;

    assign stalled = valid && !ready;

    // Stall counter: counts consecutive stalled edges, parks at TIMEOUT.
    always_comb begin
        stall_next = '0;
        if (stalled) begin
            if (stall_cnt == SW'(TIMEOUT)) begin
                stall_next = stall_cnt;
            end else begin
                stall_next = stall_cnt + SW'(1);
            end
        end
    end

    // A stall last edge obliges valid to stay up with an unchanged payload.
    assign stable_err  = stalled_q && (!valid || (payload != payload_q));
    assign timeout_err = (stall_next == SW'(TIMEOUT));

    // Stall history and counter; reset wipes history so no check fires right after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stalled_q <= 1'b0;
            payload_q <= '0;
            stall_cnt <= '0;
        end else begin
            stalled_q <= stalled;
            payload_q <= payload;
            stall_cnt <= stall_next;
        end
    end

endmodule

// File: rtl/axi4_lite_monitor.sv
// rtl/axi4_lite_monitor.sv - passive AXI4-Lite protocol checker and transaction counter
module axi4_lite_monitor
    import axi4_lite_pkg::*;
#(
    parameter int AWIDTH          = 12,
    parameter int DWIDTH          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 256,
    parameter int CWIDTH          = 32,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 2)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_arValid,
    input  logic                  i_arReady,
    input  logic [AWIDTH-1:0]     i_arAddr,
    input  logic [PROT_W-1:0]     i_arProt,
    input  logic                  i_rValid,
    input  logic                  i_rReady,
    input  logic [DWIDTH-1:0]     i_rData,
    input  logic [1:0]            i_rResp,
    input  logic                  i_awValid,
    input  logic                  i_awReady,
    input  logic [AWIDTH-1:0]     i_awAddr,
    input  logic [PROT_W-1:0]     i_awProt,
    input  logic                  i_wValid,
    input  logic                  i_wReady,
    input  logic [DWIDTH-1:0]     i_wData,
    input  logic [DWIDTH/8-1:0]   i_wStrb,
    input  logic                  i_bValid,
    input  logic                  i_bReady,
    input  logic [1:0]            i_bResp,
    input  logic                  i_clear,
    output logic [VIO_COUNT-1:0]  o_violation,
    output logic                  o_violationPulse,
    output logic [3:0]            o_firstErrCode,
    output logic [CWIDTH-1:0]     o_firstErrCycle,
    output logic [CWIDTH-1:0]     o_rdCount,
    output logic [CWIDTH-1:0]     o_wrCount,
    output logic [CWIDTH-1:0]     o_errRespCount,
    output logic [OW-1:0]         o_rdOutstanding
);

    localparam logic [OW-1:0] MAXP1 = OW'(MAX_OUTSTANDING + 1);

    logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic              legal_r, legal_b;
    logic [4:0]        stable_err, timeout_err;
    logic [OW-1:0]     aw_pend, w_pend;
    logic [OW-1:0]     rd_next, aw_next, w_next;
    logic [CWIDTH-1:0] cycle_cnt;
    logic [VIO_COUNT-1:0] det, base;
    logic [3:0]        first_idx;

    assign ar_hs = i_arValid && i_arReady;
    assign r_hs  = i_rValid  && i_rReady;
    assign aw_hs = i_awValid && i_awReady;
    assign w_hs  = i_wValid  && i_wReady;
    assign b_hs  = i_bValid  && i_bReady;

    assign legal_r = r_hs && (o_rdOutstanding != '0);
    assign legal_b = b_hs && (aw_pend != '0) && (w_pend != '0);

    function automatic logic [OW-1:0] track_next(input logic [OW-1:0] cur,
                                                 input logic inc, input logic dec);
        logic [OW-1:0] nxt;
        nxt = cur;
        if (inc && !dec && (cur != MAXP1)) nxt = cur + OW'(1);
        if (dec && !inc && (cur != '0))    nxt = cur - OW'(1);
        return nxt;
    endfunction

    assign rd_next = track_next(o_rdOutstanding, ar_hs, legal_r);
    assign aw_next = track_next(aw_pend, aw_hs, legal_b);
    assign w_next  = track_next(w_pend, w_hs, legal_b);

    axi4_lite_chan_check #(.PW(AWIDTH + PROT_W), .TIMEOUT(TIMEOUT)) u_ar_check (
        .clk(i_clk), .rst(i_rst), .valid(i_arValid), .ready(i_arReady),
        .payload({i_arAddr, i_arProt}), .stable_err(stable_err[0]), .timeout_err(timeout_err[0]));
    axi4_lite_chan_check #(.PW(DWIDTH + 2), .TIMEOUT(TIMEOUT)) u_r_check (
        .clk(i_clk), .rst(i_rst), .valid(i_rValid), .ready(i_rReady),
        .payload({i_rData, i_rResp}), .stable_err(stable_err[1]), .timeout_err(timeout_err[1]));
    axi4_lite_chan_check #(.PW(AWIDTH + PROT_W), .TIMEOUT(TIMEOUT)) u_aw_check (
        .clk(i_clk), .rst(i_rst), .valid(i_awValid), .ready(i_awReady),
        .payload({i_awAddr, i_awProt}), .stable_err(stable_err[2]), .timeout_err(timeout_err[2]));
    axi4_lite_chan_check #(.PW(DWIDTH + DWIDTH/8), .TIMEOUT(TIMEOUT)) u_w_check (
        .clk(i_clk), .rst(i_rst), .valid(i_wValid), .ready(i_wReady),
        .payload({i_wData, i_wStrb}), .stable_err(stable_err[3]), .timeout_err(timeout_err[3]));
    axi4_lite_chan_check #(.PW(2), .TIMEOUT(TIMEOUT)) u_b_check (
        .clk(i_clk), .rst(i_rst), .valid(i_bValid), .ready(i_bReady),
        .payload(i_bResp), .stable_err(stable_err[4]), .timeout_err(timeout_err[4]));

    // Violations detected at this edge; overflow fires only on the step into MAX+1.
    always_comb begin
        det = '0;
        det[VIO_B_STABLE:VIO_AR_STABLE] = stable_err;
        det[VIO_R_UNEXPECTED] = r_hs && (o_rdOutstanding == '0);
        det[VIO_B_UNEXPECTED] = b_hs && !legal_b;
        det[VIO_OVERFLOW] = ((rd_next == MAXP1) && (o_rdOutstanding != MAXP1)) ||
                            ((aw_next == MAXP1) && (aw_pend != MAXP1)) ||
                            ((w_next == MAXP1) && (w_pend != MAXP1));
        det[VIO_TIMEOUT] = |timeout_err;
        base = i_clear ? '0 : o_violation;
    end

    // Lowest set index wins when several violations land on the same edge.
    always_comb begin
        first_idx = '0;
        for (int i = VIO_COUNT - 1; i >= 0; i--) begin
            if (det[i]) first_idx = 4'(i);
        end
    end

    // Counters, outstanding tracking, sticky violations and first-error capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycle_cnt        <= '0;
            aw_pend          <= '0;
            w_pend           <= '0;
            o_rdOutstanding  <= '0;
            o_rdCount        <= '0;
            o_wrCount        <= '0;
            o_errRespCount   <= '0;
            o_violation      <= '0;
            o_violationPulse <= 1'b0;
            o_firstErrCode   <= '0;
            o_firstErrCycle  <= '0;
        end else begin
            cycle_cnt       <= cycle_cnt + CWIDTH'(1);
            aw_pend         <= aw_next;
            w_pend          <= w_next;
            o_rdOutstanding <= rd_next;
            o_rdCount       <= o_rdCount + CWIDTH'(r_hs);
            o_wrCount       <= o_wrCount + CWIDTH'(b_hs);
            o_errRespCount  <= o_errRespCount + CWIDTH'(r_hs && is_err_resp(i_rResp))
                                              + CWIDTH'(b_hs && is_err_resp(i_bResp));
            o_violation      <= base | det;
            o_violationPulse <= |(det & ~base);
            if ((base == '0) && (det != '0)) begin
                o_firstErrCode  <= first_idx;
                o_firstErrCycle <= cycle_cnt;
            end else if (i_clear) begin
                o_firstErrCode  <= '0;
                o_firstErrCycle <= '0;
            end
        end
    end

endmodule

// File: doc/axi4_lite_monitor.md
Name: axi4_lite_monitor

Overview:
- Passive AXI4-Lite protocol checker and transaction counter. Taps every signal between the AXI4-Lite driver (master) and the AXI4-Lite slave in the test harness.
- Observes the bus only and drives no bus signal.
- Reports sticky protocol violations, the first violation and the cycle it occurred in, and read, write and error-response counts to the bench.

Parameters:
- AWIDTH, 12, address width of araddr and awaddr.
- DWIDTH, 32, data width; wStrb is DWIDTH/8.
- MAX_OUTSTANDING, 4, legal number of accepted but unanswered transactions per direction.
- TIMEOUT, 256, consecutive stalled cycles (valid=1, ready=0) that flag a hang.
- CWIDTH, 32, width of all counters.

Ports:
- i_clk  in  1  single clock for bus and monitor
- i_rst  in  1  synchronous, active-high reset
- i_arValid, i_arReady  in  1  read address handshake
- i_arAddr  in  AWIDTH  read address
- i_arProt  in  3  read protection
- i_rValid, i_rReady  in  1  read data handshake
- i_rData  in  DWIDTH  read data
- i_rResp  in  2  read response
- i_awValid, i_awReady  in  1  write address handshake
- i_awAddr  in  AWIDTH  write address
- i_awProt  in  3  write protection
- i_wValid, i_wReady  in  1  write data handshake
- i_wData  in  DWIDTH  write data
- i_wStrb  in  DWIDTH/8  write strobes
- i_bValid, i_bReady  in  1  write response handshake
- i_bResp  in  2  write response
- i_clear  in  1  clears sticky violations and the first-error capture; counters are kept
- o_violation  out  9  sticky violation bits
- o_violationPulse  out  1  high for one cycle when any violation bit is newly set
- o_firstErrCode  out  4  index of the first violation since reset or clear
- o_firstErrCycle  out  CWIDTH  cycle count at which the first violation occurred
- o_rdCount  out  CWIDTH  completed R handshakes
- o_wrCount  out  CWIDTH  completed B handshakes
- o_errRespCount  out  CWIDTH  R or B handshakes with resp of SLVERR or DECERR
- o_rdOutstanding  out  clog2(MAX_OUTSTANDING+2)  accepted reads not yet answered

Behaviour:
- Reset: all outputs 0, all internal state 0, and stall history cleared, so no stability check runs in the first cycle after reset.
- Reset mid-transaction discards all outstanding tracking.
- Cycle counter increments every non-reset cycle and wraps.
- Handshake on a channel means valid && ready at the rising edge.
- Stability bits, per channel (bit 0 AR, 1 R, 2 AW, 3 W, 4 B):
  - If valid=1 and ready=0 in cycle n, then in cycle n+1 valid must be 1 and the payload must equal its cycle-n value.
  - Payloads compared: AR = addr+prot; R = data+resp; AW = addr+prot; W = data+strb; B = resp.
  - Otherwise set that channel's bit in cycle n+1.
- Bit 5 R_UNEXPECTED: an R handshake while rdOutstanding=0, using the pre-update value. AR and R handshaking in the same cycle with rdOutstanding=0 is therefore a violation.
- Write tracking: awPend and wPend count independently. A B handshake needs awPend>0 and wPend>0, else set bit 6 B_UNEXPECTED. A legal B decrements both.
- Counter update rule: next = cur + handshake_in − legal_response. Counters saturate at 0 and at MAX_OUTSTANDING+1.
- Bit 7 OVERFLOW: any of rdOutstanding, awPend or wPend reaches MAX_OUTSTANDING+1.
- Bit 8 TIMEOUT: each channel has a stall counter that increments while valid && !ready and clears otherwise. The bit is set when any stall counter equals TIMEOUT; the counter saturates there.
- First-error capture: on the first newly set bit, latch its index and the cycle counter. If several bits set in the same cycle, the lowest index wins.
- o_violationPulse asserts in the same cycle the bit becomes visible, registered (1 cycle after the offending edge).
- i_clear: violation bits, first-error capture and pulse go to 0 next cycle. A violation detected in the same cycle as clear wins and is set.
- Latency: every output is registered, one cycle after the observed edge.

Decomposition:
- Package axi4_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - violation index localparams VIO_AR_STABLE..VIO_TIMEOUT (0..8) and VIO_COUNT=9.
  - prot width constant (3).
- Sub-module axi4_lite_chan_check, parameterised by payload width and TIMEOUT. It holds the stall history register, payload compare and stall counter, and outputs stableErr and timeoutErr. It is instantiated five times.

Test Plan:
- Legal traffic: write addr 0x010 data 0xDEADBEEF strb 0xF with AW before W, then a read of 0x010 returning OKAY. Expect o_wrCount=1, o_rdCount=1, o_violation=0, o_rdOutstanding back to 0.
- Stability: arValid=1, arReady=0, arAddr changes 0x004→0x008 next cycle. Expect o_violation[0]=1, o_firstErrCode=0, one-cycle o_violationPulse.
- Unexpected responses: rValid&&rReady with no prior AR. Expect bit 5. Then a B handshake after only a W handshake. Expect bit 6, with o_firstErrCode still 5.
- Overflow and timeout: 5 AR handshakes with no R. Expect bit 7. Then wValid=1, wReady=0 for 256 cycles. Expect bit 8 exactly at stall cycle 256.
- Error responses: R with rResp=SLVERR, then B with DECERR. Expect o_errRespCount=2 and no violations.
- Clear/reset: raise i_clear in the same cycle as a new R_STABLE violation. Expect bit 1 set, all other bits cleared. Assert i_rst with 2 reads outstanding. Expect all outputs 0 and a subsequent R flags bit 5.
